// File: rtl/shift_sequencer_if.sv
// shift_sequencer_if: request, response and shifter-side signals of the shift sequencer
interface shift_sequencer_if #(parameter int CNT_W = 5);
  logic             req_valid;
  logic             req_ready;
  logic [7:0]       req_data;
  logic [CNT_W-1:0] req_amt;
  logic             req_lr;
  logic             req_al;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [7:0]       rsp_data;
  logic             busy;
  logic [7:0]       sh_din;
  logic [2:0]       sh_shamt;
  logic             sh_lr;
  logic             sh_al;
  logic [7:0]       sh_dout;
  modport slave (
    input  req_valid, req_data, req_amt, req_lr, req_al, rsp_ready, sh_dout,
    output req_ready, rsp_valid, rsp_data, busy, sh_din, sh_shamt, sh_lr, sh_al
  );
  modport master (
    output req_valid, req_data, req_amt, req_lr, req_al, rsp_ready, sh_dout,
    input  req_ready, rsp_valid, rsp_data, busy, sh_din, sh_shamt, sh_lr, sh_al
  );
endinterface

// File: rtl/shift_sequencer.sv
// shift_sequencer: splits a long shift into passes of at most 7 through an external 8-bit barrel shifter
module shift_sequencer #(parameter int CNT_W = 5) (
  input logic             clk,
  input logic             rst_n,
  shift_sequencer_if.slave io_bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t           r_state;
  logic [7:0]       r_acc;
  logic [CNT_W-1:0] r_rem;
  logic             r_lr;
  logic             r_al;
  logic             w_last;
  logic [2:0]       w_step;
  assign w_last            = r_rem <= CNT_W'(7);
  assign w_step            = w_last ? r_rem[2:0] : 3'd7;
  assign io_bus.req_ready  = r_state == IDLE;
  assign io_bus.rsp_valid  = r_state == DONE;
  assign io_bus.busy       = r_state != IDLE;
  assign io_bus.rsp_data   = r_acc;
  assign io_bus.sh_din     = r_acc;
  assign io_bus.sh_shamt   = r_state == SHIFT ? w_step : 3'd0;
  assign io_bus.sh_lr      = r_lr;
  assign io_bus.sh_al      = r_al;
  // Sequencer FSM: latch request, fold shifter output back into acc each pass, hold result until taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_acc   <= 8'h00;
      r_rem   <= '0;
      r_lr    <= 1'b0;
      r_al    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (io_bus.req_valid) begin
          r_acc   <= io_bus.req_data;
          r_rem   <= io_bus.req_amt;
          r_lr    <= io_bus.req_lr;
          r_al    <= io_bus.req_al;
          r_state <= io_bus.req_amt != '0 ? SHIFT : DONE;
        end
        SHIFT: begin
          r_acc   <= io_bus.sh_dout;
          r_rem   <= r_rem - CNT_W'(w_step);
          r_state <= w_last ? DONE : SHIFT;
        end
        DONE: r_state <= io_bus.rsp_ready ? IDLE : DONE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: directed checks of the shift sequencer against a behavioural barrel shifter
module tb_shift_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  int cyc;
  logic [31:0] passes;
  logic [7:0] w_asr;
  shift_sequencer_if #(.CNT_W(5)) b();
  shift_sequencer #(.CNT_W(5)) dut (.clk(clk), .rst_n(rst_n), .io_bus(b));
  always #5 clk = ~clk;
  // Behavioural 8-bit barrel shifter closing the loop through sh_*
  assign w_asr = $signed(b.sh_din) >>> b.sh_shamt;
  assign b.sh_dout = b.sh_lr ? (b.sh_din << b.sh_shamt) : b.sh_al ? w_asr : (b.sh_din >> b.sh_shamt);
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // Counts cycles from cycle 1 until rsp_valid, packing each cycle's sh_shamt 3 bits at a time
  task automatic wait_rsp(output int n, output logic [31:0] p);
    n = 1;
    p = 0;
    while (!b.rsp_valid && n < 64) begin
      p = (p << 3) | 32'(b.sh_shamt);
      @(negedge clk);
      n++;
    end
  endtask
  task automatic run(input logic [7:0] d, input logic [4:0] a, input logic lr, input logic al);
    b.req_data = d;
    b.req_amt = a;
    b.req_lr = lr;
    b.req_al = al;
    b.req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b.req_valid = 1'b0;
    wait_rsp(cyc, passes);
  endtask
  task automatic consume(input string tag);
    b.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b.rsp_ready = 1'b0;
    check({tag, "_idle_rdy"}, 32'(b.req_ready), 1);
    check({tag, "_idle_vld"}, 32'(b.rsp_valid), 0);
  endtask
  initial begin
    int viol;
    b.req_valid = 1'b0;
    b.req_data = 8'h00;
    b.req_amt = 5'd0;
    b.req_lr = 1'b0;
    b.req_al = 1'b0;
    b.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst_req_ready", 32'(b.req_ready), 1);
    check("rst_rsp_valid", 32'(b.rsp_valid), 0);
    check("rst_busy", 32'(b.busy), 0);
    check("rst_rsp_data", 32'(b.rsp_data), 0);
    check("rst_sh", {b.sh_din, b.sh_shamt, b.sh_lr, b.sh_al}, 0);
    run(8'h81, 5'd3, 1'b1, 1'b0);
    check("t1_cyc", cyc, 2);
    check("t1_passes", passes, 32'o3);
    check("t1_data", 32'(b.rsp_data), 32'h08);
    consume("t1");
    run(8'h80, 5'd10, 1'b0, 1'b1);
    check("t2_cyc", cyc, 3);
    check("t2_passes", passes, 32'o73);
    check("t2_data", 32'(b.rsp_data), 32'hFF);
    consume("t2");
    run(8'h5A, 5'd0, 1'b0, 1'b0);
    check("t3_cyc", cyc, 1);
    check("t3_shamt", 32'(b.sh_shamt), 0);
    check("t3_busy", 32'(b.busy), 1);
    check("t3_data", 32'(b.rsp_data), 32'h5A);
    consume("t3");
    b.req_data = 8'hB4;
    b.req_amt = 5'd31;
    b.req_lr = 1'b0;
    b.req_al = 1'b0;
    b.req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b.req_data = 8'h03;
    b.req_amt = 5'd1;
    b.req_lr = 1'b1;
    viol = 0;
    cyc = 1;
    passes = 0;
    while (!b.rsp_valid && cyc < 64) begin
      if (b.req_ready || !b.busy) viol++;
      passes = (passes << 3) | 32'(b.sh_shamt);
      @(negedge clk);
      cyc++;
    end
    check("t4_cyc", cyc, 6);
    check("t4_passes", passes, 32'o77773);
    check("t4_hold", viol, 0);
    check("t4_done_rdy", 32'(b.req_ready), 0);
    check("t4_data", 32'(b.rsp_data), 32'h00);
    consume("t4");
    check("t4_idle_busy", 32'(b.busy), 0);
    @(posedge clk);
    @(negedge clk);
    b.req_valid = 1'b0;
    check("t4b_accept", 32'(b.busy), 1);
    wait_rsp(cyc, passes);
    check("t4b_cyc", cyc, 2);
    check("t4b_data", 32'(b.rsp_data), 32'h06);
    consume("t4b");
    run(8'hF0, 5'd4, 1'b0, 1'b0);
    check("t5_cyc", cyc, 2);
    for (int i = 0; i < 5; i++) begin
      check("t5_hold_vld", 32'(b.rsp_valid), 1);
      check("t5_hold_data", 32'(b.rsp_data), 32'h0F);
      @(negedge clk);
    end
    check("t5_hold_vld", 32'(b.rsp_valid), 1);
    consume("t5");
    b.req_data = 8'h01;
    b.req_amt = 5'd14;
    b.req_lr = 1'b1;
    b.req_al = 1'b0;
    b.req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b.req_valid = 1'b0;
    check("t6_shift_amt", 32'(b.sh_shamt), 7);
    rst_n = 1'b0;
    #1;
    check("t6_rst_rdy", 32'(b.req_ready), 1);
    check("t6_rst_vld", 32'(b.rsp_valid), 0);
    check("t6_rst_busy", 32'(b.busy), 0);
    check("t6_rst_data", 32'(b.rsp_data), 0);
    check("t6_rst_sh", {b.sh_din, b.sh_shamt, b.sh_lr, b.sh_al}, 0);
    viol = 0;
    repeat (3) begin
      @(negedge clk);
      if (b.rsp_valid) viol++;
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (b.rsp_valid || b.busy) viol++;
    end
    check("t6_no_rsp", viol, 0);
    run(8'h01, 5'd1, 1'b1, 1'b0);
    check("t6b_cyc", cyc, 2);
    check("t6b_data", 32'(b.rsp_data), 32'h02);
    consume("t6b");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
